// File: rtl/irq_sched_pkg.sv
// Shared constants, state type and helpers for the 10-source interrupt scheduler.
package irq_sched_pkg;

    localparam int unsigned N_SRC = 10;
    localparam int unsigned ID_W  = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Bits strictly below index id are set; id=0 gives an empty mask.
    function automatic logic [N_SRC-1:0] below_mask(input logic [ID_W-1:0] id);
        logic [N_SRC-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            m[i] = (ID_W'(i) < id);
        end
        return m;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_SRC-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            m[i] = (ID_W'(i) == id);
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-index encoder with an any-set flag.
module prio_enc_n #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/irq_sched10.sv
// Interrupt scheduler: edge capture into pending, mask, fixed/round-robin pick,
// grant held until acknowledged.
module irq_sched10
    import irq_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [N_SRC-1:0]  mask,
    input  logic              en,
    input  logic              mode_sel,
    input  logic              irq_ack,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    output logic [N_SRC-1:0]  pending
);

    state_t            r_state;
    state_t            w_state_next;
    logic [N_SRC-1:0]  r_irq_in_d;
    logic [N_SRC-1:0]  r_pending;
    logic              r_valid;
    logic              w_valid_next;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   w_id_next;
    logic [ID_W-1:0]   r_rr_last;
    logic [ID_W-1:0]   w_rr_last_next;

    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  w_clr;
    logic [N_SRC-1:0]  w_eligible;
    logic [N_SRC-1:0]  w_eligible_rr;
    logic [ID_W-1:0]   w_all_id;
    logic              w_all_any;
    logic [ID_W-1:0]   w_rr_id;
    logic              w_rr_any;
    logic [ID_W-1:0]   w_sel_id;

    assign w_rise        = irq_in & ~r_irq_in_d;
    assign w_eligible    = r_pending & mask;
    assign w_eligible_rr = w_eligible & below_mask(r_rr_last);

    prio_enc_n #(
        .N (N_SRC),
        .W (ID_W)
    ) u_enc_all (
        .i_vec (w_eligible),
        .o_idx (w_all_id),
        .o_any (w_all_any)
    );

    prio_enc_n #(
        .N (N_SRC),
        .W (ID_W)
    ) u_enc_rr (
        .i_vec (w_eligible_rr),
        .o_idx (w_rr_id),
        .o_any (w_rr_any)
    );

    // Round-robin falls back to the plain highest index when nothing lies below rr_last.
    assign w_sel_id = (mode_sel == MODE_RR && w_rr_any) ? w_rr_id : w_all_id;

    always_comb begin
        w_state_next   = r_state;
        w_valid_next   = r_valid;
        w_id_next      = r_id;
        w_rr_last_next = r_rr_last;
        w_clr          = '0;
        unique case (r_state)
            IDLE: begin
                if (en && w_all_any) begin
                    w_state_next = GRANT;
                    w_valid_next = 1'b1;
                    w_id_next    = w_sel_id;
                end
            end
            GRANT: begin
                if (irq_ack) begin
                    w_clr          = onehot(r_id);
                    w_state_next   = IDLE;
                    w_valid_next   = 1'b0;
                    w_rr_last_next = r_id;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_irq_in_d <= '0;
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_rr_last  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_irq_in_d <= irq_in;
            // A new rise wins over the ack clear of the same source.
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_valid    <= w_valid_next;
            r_id       <= w_id_next;
            r_rr_last  <= w_rr_last_next;
        end
    end

    assign irq_valid = r_valid;
    assign irq_id    = r_id;
    assign pending   = r_pending;

endmodule

// File: tb/tb_irq_sched10.sv
// Directed bench for irq_sched10 with hand-computed expectations.
module tb_irq_sched10;

    logic        clk;
    logic        rst;
    logic [9:0]  irq_in;
    logic [9:0]  mask;
    logic        en;
    logic        mode_sel;
    logic        irq_ack;
    logic        irq_valid;
    logic [3:0]  irq_id;
    logic [9:0]  pending;

    int n_checks;
    int n_errors;

    irq_sched10 u_dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .en        (en),
        .mode_sel  (mode_sel),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic ack_step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    int rr_exp[5] = '{7, 4, 1, 7, 4};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        irq_in   = '0;
        mask     = 10'h3FF;
        en       = 1'b1;
        mode_sel = 1'b0;
        irq_ack  = 1'b0;
        #2;
        do_reset();

        // 1: single source
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'h000);
        check("rst_id", 32'(irq_id), 32'd0);
        irq_in = 10'h008;
        step();
        check("t1_pend", 32'(pending), 32'h008);
        check("t1_novalid_yet", 32'(irq_valid), 32'd0);
        step();
        check("t1_valid", 32'(irq_valid), 32'd1);
        check("t1_id", 32'(irq_id), 32'd3);
        ack_step();
        check("t1_ack_valid", 32'(irq_valid), 32'd0);
        check("t1_ack_pend", 32'(pending), 32'h000);
        irq_in = '0;
        step();

        // 2: fixed priority 9,5,2
        irq_in = 10'h224;
        step();
        check("t2_pend", 32'(pending), 32'h224);
        step();
        check("t2_id9", 32'(irq_id), 32'd9);
        ack_step();
        check("t2_gap1", 32'(irq_valid), 32'd0);
        check("t2_pend1", 32'(pending), 32'h024);
        step();
        check("t2_id5", 32'(irq_id), 32'd5);
        check("t2_v5", 32'(irq_valid), 32'd1);
        ack_step();
        check("t2_gap2", 32'(irq_valid), 32'd0);
        step();
        check("t2_id2", 32'(irq_id), 32'd2);
        ack_step();
        check("t2_pend_end", 32'(pending), 32'h000);
        irq_in = '0;
        step();

        // 3: round robin with re-raised 1,4,7
        do_reset();
        mode_sel = 1'b1;
        irq_in   = 10'h092;
        step();
        step();
        check("t3_v0", 32'(irq_valid), 32'd1);
        check("t3_id0", 32'(irq_id), 32'(rr_exp[0]));
        for (int k = 1; k < 5; k++) begin
            irq_in = '0;
            ack_step();
            check("t3_gap", 32'(irq_valid), 32'd0);
            irq_in = 10'h092;
            step();
            check("t3_valid", 32'(irq_valid), 32'd1);
            check($sformatf("t3_id%0d", k), 32'(irq_id), 32'(rr_exp[k]));
        end
        ack_step();
        irq_in   = '0;
        mode_sel = 1'b0;
        do_reset();

        // 4: masked source stays pending until unmasked
        mask   = 10'h3BF;
        irq_in = 10'h040;
        step();
        step();
        step();
        check("t4_masked_valid", 32'(irq_valid), 32'd0);
        check("t4_masked_pend", 32'(pending), 32'h040);
        mask = 10'h3FF;
        step();
        check("t4_valid", 32'(irq_valid), 32'd1);
        check("t4_id", 32'(irq_id), 32'd6);
        ack_step();
        check("t4_pend_end", 32'(pending), 32'h000);
        irq_in = '0;
        step();

        // 5: re-rise on ack cycle keeps pending and re-grants; grant held through input changes
        irq_in = 10'h004;
        step();
        step();
        check("t5_id", 32'(irq_id), 32'd2);
        irq_in   = '0;
        mask     = 10'h000;
        en       = 1'b0;
        mode_sel = 1'b1;
        step();
        check("t5_hold_valid", 32'(irq_valid), 32'd1);
        check("t5_hold_id", 32'(irq_id), 32'd2);
        mask     = 10'h3FF;
        en       = 1'b1;
        mode_sel = 1'b0;
        irq_in   = 10'h004;
        ack_step();
        check("t5_ack_valid", 32'(irq_valid), 32'd0);
        check("t5_setwins", 32'(pending), 32'h004);
        step();
        check("t5_regrant_v", 32'(irq_valid), 32'd1);
        check("t5_regrant_id", 32'(irq_id), 32'd2);
        ack_step();
        check("t5_pend_end", 32'(pending), 32'h000);
        irq_in = '0;
        step();

        // 6: en gating, reset mid-grant, restart
        en     = 1'b0;
        irq_in = 10'h021;
        step();
        step();
        step();
        check("t6_en0_valid", 32'(irq_valid), 32'd0);
        check("t6_en0_pend", 32'(pending), 32'h021);
        en = 1'b1;
        step();
        check("t6_id5", 32'(irq_id), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", 32'(irq_valid), 32'd0);
        check("t6_rst_pend", 32'(pending), 32'h000);
        check("t6_rst_id", 32'(irq_id), 32'd0);
        step();
        check("t6_recap", 32'(pending), 32'h021);
        step();
        check("t6_restart_id", 32'(irq_id), 32'd5);
        ack_step();
        step();
        check("t6_next_valid", 32'(irq_valid), 32'd1);
        check("t6_next_id", 32'(irq_id), 32'd0);
        ack_step();
        irq_in = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
